// File: rtl/mips_ctrl_pkg.sv
// Shared control definitions for the MIPS pipeline control blocks.
// Contents:
//   mul_state_e   - multiplier sequencer states (IDLE / BUSY / PEND)
//   REG_ZERO      - architectural zero register address
//   OP_* / FUNCT_ - opcode and funct encodings shared with the decoder
//   is_mul_op()   - helper that recognises the multiply encoding
package mips_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_PEND = 2'd2
  } mul_state_e;

  localparam logic [4:0] REG_ZERO  = 5'd0;

  localparam logic [5:0] OP_RTYPE  = 6'h04;
  localparam logic [5:0] FUNCT_MUL = 6'h32;
  localparam logic [5:0] OP_LW     = 6'h05;
  localparam logic [5:0] OP_SW     = 6'h06;

  function automatic logic is_mul_op(input logic [5:0] opcode, input logic [5:0] funct);
    return (opcode == OP_RTYPE) && (funct == FUNCT_MUL);
  endfunction

endpackage

// File: rtl/mul_watchdog.sv
// Cycle counter that bounds how long a multiply may stay in flight.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   clr_i       - restart the count at zero (a new multiply launches)
//   en_i        - count this cycle (multiply in flight, result not back)
//   expire_o    - counting and the count has reached MUL_TIMEOUT-1
module mul_watchdog #(
  parameter int MUL_TIMEOUT = 64,
  localparam int CW = (MUL_TIMEOUT > 1) ? $clog2(MUL_TIMEOUT) : 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  logic [CW-1:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clr_i) begin
      count_q <= '0;
    end else if (en_i) begin
      count_q <= count_q + CW'(1);
    end
  end

  // The largest count value is MUL_TIMEOUT-1, which always fits in CW bits.
  assign expire_o = en_i && (count_q == CW'(MUL_TIMEOUT - 1));

endmodule

// File: rtl/mul_issue_ctrl.sv
// Issue and writeback sequencer for the multi-cycle multiplier.
// Launches one multiply at a time, lets independent instructions issue while
// it runs, stalls decode on hazards against the in-flight destination and
// shares the register-file write port with the normal writeback path.
//
// Handshake: mul_go is a one-cycle launch pulse in the same cycle as id_issue;
// mul_done is a one-cycle pulse from the multiplier, honoured only in BUSY.
// A multiply result is written when wb_mul_we=1; the normal writeback
// (wb_alu_we) always has priority for the shared port.
//
// Ports:
//   clk, rst_n        - clock, asynchronous active-low reset
//   id_valid/id_mul   - instruction present in ID / it is a multiply
//   id_wr_regfile     - ID instruction writes the register file
//   id_rs/id_rt/id_rd - ID source and destination registers
//   wb_alu_we         - normal writeback owns the write port this cycle
//   mul_done          - multiplier result available (pulse)
//   mul_go            - launch multiplier
//   stall             - hold IF/ID, bubble into ID/EX
//   id_issue          - ID instruction accepted
//   wb_mul_we/sel     - write multiplier result / select it in the WB mux
//   wb_mul_addr       - destination of the multiplier write
//   busy              - a multiply is in flight or awaiting writeback
//   timeout_err       - sticky watchdog abort flag
module mul_issue_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int MUL_TIMEOUT = 64,
  parameter int REG_AW      = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic              id_mul,
  input  logic              id_wr_regfile,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              wb_alu_we,
  input  logic              mul_done,
  output logic              mul_go,
  output logic              stall,
  output logic              id_issue,
  output logic              wb_mul_we,
  output logic              wb_mul_sel,
  output logic [REG_AW-1:0] wb_mul_addr,
  output logic              busy,
  output logic              timeout_err
);

  mul_state_e        state_q;
  logic [REG_AW-1:0] mul_rd_q;
  logic              timeout_err_q;
  logic              wd_expire;

  logic in_flight;
  logic rd_live;
  logic haz_mul;
  logic haz_raw;
  logic haz_waw;
  logic port_free;

  assign in_flight = (state_q != ST_IDLE);
  // A zero destination is never written, so it cannot create a hazard.
  assign rd_live   = (mul_rd_q != REG_AW'(REG_ZERO));

  assign haz_mul = in_flight && id_mul;
  // rt is compared for every format; a false stall is harmless.
  assign haz_raw = in_flight && rd_live && ((id_rs == mul_rd_q) || (id_rt == mul_rd_q));
  assign haz_waw = in_flight && rd_live && id_wr_regfile && (id_rd == mul_rd_q);

  // PEND stalls everything so the pipe drains and frees a write slot.
  assign stall    = id_valid && (haz_mul || haz_raw || haz_waw || (state_q == ST_PEND));
  assign id_issue = id_valid && !stall;
  assign mul_go   = (state_q == ST_IDLE) && id_valid && id_mul;

  assign port_free   = (state_q == ST_PEND) && !wb_alu_we;
  assign wb_mul_we   = port_free && rd_live;
  assign wb_mul_sel  = wb_mul_we;
  assign wb_mul_addr = (state_q == ST_PEND) ? mul_rd_q : '0;
  assign busy        = in_flight;
  assign timeout_err = timeout_err_q;

  mul_watchdog #(
    .MUL_TIMEOUT(MUL_TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (mul_go),
    .en_i    (state_q == ST_BUSY),
    .expire_o(wd_expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      mul_rd_q      <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (mul_go) begin
            state_q  <= ST_BUSY;
            mul_rd_q <= id_rd;
          end
        end
        ST_BUSY: begin
          // A done arriving on the expiry cycle still counts as a result.
          if (mul_done) begin
            state_q <= ST_PEND;
          end else if (wd_expire) begin
            state_q       <= ST_IDLE;
            timeout_err_q <= 1'b1;
          end
        end
        ST_PEND: begin
          // Exit on the first free slot, even when the write is suppressed.
          if (port_free) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_issue_ctrl.sv
module tb_mul_issue_ctrl;
  localparam int T  = 4;
  localparam int AW = 5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          id_valid = 0, id_mul = 0, id_wr_regfile = 0, wb_alu_we = 0, mul_done = 0;
  logic [AW-1:0] id_rs = 0, id_rt = 0, id_rd = 0;
  logic          mul_go, stall, id_issue, wb_mul_we, wb_mul_sel, busy, timeout_err;
  logic [AW-1:0] wb_mul_addr;

  mul_issue_ctrl #(.MUL_TIMEOUT(T), .REG_AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_mul(id_mul),
    .id_wr_regfile(id_wr_regfile), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .wb_alu_we(wb_alu_we), .mul_done(mul_done), .mul_go(mul_go), .stall(stall),
    .id_issue(id_issue), .wb_mul_we(wb_mul_we), .wb_mul_sel(wb_mul_sel),
    .wb_mul_addr(wb_mul_addr), .busy(busy), .timeout_err(timeout_err)
  );

  int checks = 0;
  int errors = 0;

  // vector: {go, stall, issue, we, sel, addr[4:0], busy, err}
  logic [11:0] exp_q[$];

  function automatic logic [11:0] act_vec();
    return {mul_go, stall, id_issue, wb_mul_we, wb_mul_sel, wb_mul_addr, busy, timeout_err};
  endfunction

  // ---------------- reference model ----------------
  // One multiply "job": launched, maybe result back, waiting for a free port.
  bit          m_inflight = 0;
  bit          m_ready = 0;
  int          m_age = 0;
  logic [AW-1:0] m_dest = 0;
  bit          m_err = 0;
  int          m_lat = 0;
  int          n_writes = 0;

  task automatic model_reset();
    m_inflight = 0; m_ready = 0; m_age = 0; m_dest = 0; m_err = 0;
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic v, input logic m, input logic w,
                       input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                       input logic [AW-1:0] rd, input logic alu, input logic done);
    logic hz, e_stall, e_issue, e_go, e_we;
    logic [AW-1:0] e_addr;
    @(negedge clk);
    id_valid = v; id_mul = m; id_wr_regfile = w;
    id_rs = rs; id_rt = rt; id_rd = rd; wb_alu_we = alu; mul_done = done;
    hz = m_inflight && (m || m_ready ||
         (m_dest != 0 && (rs == m_dest || rt == m_dest || (w && rd == m_dest))));
    e_stall = v && hz;
    e_issue = v && !e_stall;
    e_go    = v && m && !m_inflight;
    e_we    = m_ready && !alu && (m_dest != 0);
    e_addr  = m_ready ? m_dest : '0;
    exp_q.push_back({e_go, e_stall, e_issue, e_we, e_we, e_addr, m_inflight, m_err});
    if (e_we) n_writes++;
    // advance the job by one cycle
    if (!m_inflight) begin
      if (e_go) begin
        m_inflight = 1; m_ready = 0; m_age = 0; m_dest = rd;
        m_lat = $urandom_range(0, T + 1);
      end
    end else if (!m_ready) begin
      if (done) m_ready = 1;
      else if (m_age == T - 1) begin m_inflight = 0; m_err = 1; end
      else m_age++;
    end else if (!alu) begin
      m_inflight = 0; m_ready = 0;
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always begin
    @(negedge clk);
    #2;
    if (rst_n && exp_q.size() > 0) begin
      logic [11:0] e, a;
      e = exp_q.pop_front();
      a = act_vec();
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL outputs t=%0t got go=%b stall=%b issue=%b we=%b sel=%b addr=%0d busy=%b err=%b want go=%b stall=%b issue=%b we=%b sel=%b addr=%0d busy=%b err=%b",
                 $time, a[11], a[10], a[9], a[8], a[7], a[6:2], a[1], a[0],
                 e[11], e[10], e[9], e[8], e[7], e[6:2], e[1], e[0]);
      end
    end
  end

  task automatic check_all_zero(input string name);
    checks++;
    if (act_vec() !== 12'd0) begin
      errors++;
      $display("FAIL %s got %b want 000000000000", name, act_vec());
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    #12;
    check_all_zero("reset_outputs");
    rst_n = 1'b1;
    idle_cycles(1);

    // multiply rd=8, independent add, dependent add waits through PEND
    drive(1, 1, 1, 1, 2, 8, 0, 0);
    drive(1, 0, 1, 3, 4, 9, 0, 0);
    drive(1, 0, 1, 8, 4, 9, 0, 1);
    drive(1, 0, 1, 8, 4, 9, 1, 0);
    drive(1, 0, 1, 8, 4, 9, 1, 0);
    drive(1, 0, 1, 8, 4, 9, 0, 0);
    drive(1, 0, 1, 8, 4, 9, 0, 0);

    // second multiply while busy waits, then issues in IDLE
    drive(1, 1, 1, 1, 2, 10, 0, 0);
    drive(1, 1, 1, 1, 2, 11, 0, 0);
    drive(1, 1, 1, 1, 2, 11, 0, 1);
    drive(1, 1, 1, 1, 2, 11, 0, 0);
    drive(1, 1, 1, 1, 2, 11, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);

    // watchdog: no done at all
    drive(1, 1, 1, 0, 0, 5, 0, 0);
    idle_cycles(T + 2);

    // zero destination: no RAW/WAW stalls, no write
    drive(1, 1, 1, 0, 0, 0, 0, 0);
    drive(1, 0, 1, 0, 0, 0, 0, 0);
    drive(1, 0, 1, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      logic dn;
      if (m_inflight && !m_ready) dn = (m_age == m_lat);
      else dn = ($urandom_range(0, 7) == 0);
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0, $urandom_range(0, 1),
            AW'($urandom_range(0, 3)), AW'($urandom_range(0, 3)), AW'($urandom_range(0, 3)),
            $urandom_range(0, 1), dn);
    end

    // reset in the middle of a multiply
    idle_cycles(T + 3);
    drive(1, 1, 1, 0, 0, 7, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    id_valid = 0; id_mul = 0; wb_alu_we = 0; mul_done = 0;
    #3;
    rst_n = 1'b0;
    #1;
    check_all_zero("reset_mid_busy");
    model_reset();
    exp_q.delete();
    #3;
    rst_n = 1'b1;
    idle_cycles(3);
    @(negedge clk);
    #3;

    checks++;
    if (n_writes == 0) begin
      errors++;
      $display("FAIL write_coverage got %0d writes want >0", n_writes);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mul_issue_ctrl.md
Name: mul_issue_ctrl

Overview:
- Issue and writeback sequencer for the multi-cycle multiplier in the MIPS CPU.
- Sits between the decode stage (control outputs: mul_Start, rs/rt/rd, WR_regfile) and the multiplier.
- Launches one multiply at a time and lets independent instructions keep issuing while it runs.
- Stalls decode on RAW/WAW hazards against the in-flight destination, and arbitrates the shared register-file write port between the multiplier result and the normal ALU/memory writeback.

Parameters:
- MUL_TIMEOUT, 64: max cycles in BUSY without mul_done before abort; legal range 2..255.
- REG_AW, 5: register address width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  decoded instruction present in ID.
- id_mul  in  1  ID instruction is a multiply (mul_Start from decode).
- id_wr_regfile  in  1  ID instruction writes the register file.
- id_rs  in  REG_AW  source register 1.
- id_rt  in  REG_AW  source register 2.
- id_rd  in  REG_AW  destination register.
- wb_alu_we  in  1  normal writeback is using the regfile write port this cycle.
- mul_done  in  1  one-cycle pulse from multiplier; result held at its output until next mul_go.
- mul_go  out  1  one-cycle launch pulse; multiplier samples operands this cycle.
- stall  out  1  hold PC and IF/ID; insert bubble into ID/EX.
- id_issue  out  1  ID instruction accepted this cycle (id_valid & !stall).
- wb_mul_we  out  1  write multiplier result to regfile this cycle.
- wb_mul_sel  out  1  writeback mux selects multiplier result (equals wb_mul_we).
- wb_mul_addr  out  REG_AW  destination for the multiplier write.
- busy  out  1  state != IDLE.
- timeout_err  out  1  sticky; set on watchdog abort.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, mul_rd=0, counter=0, timeout_err=0.
  - All outputs at reset: mul_go=0, stall=0, id_issue=0, wb_mul_we=0, wb_mul_sel=0, wb_mul_addr=0, busy=0.
  - Reset mid-multiply abandons the operation; no writeback occurs.
- States:
  - IDLE: no multiply in flight.
  - BUSY: waiting for mul_done.
  - PEND: result ready, waiting for a free write port.
- IDLE:
  - mul_go = id_valid & id_mul, combinational, in the same cycle as id_issue.
  - On that edge: mul_rd <= id_rd, counter <= 0, go to BUSY.
  - mul_done is ignored in IDLE.
- BUSY:
  - counter increments each cycle.
  - mul_done=1 -> PEND.
  - counter == MUL_TIMEOUT-1 without done -> timeout_err <= 1, go to IDLE, no writeback.
  - mul_done on the same edge as timeout: done wins.
- PEND:
  - wb_mul_we = !wb_alu_we (combinational).
  - When wb_mul_we=1 -> IDLE next edge.
  - When wb_alu_we=1, the ALU write has priority; remain in PEND.
- Writeback: wb_mul_addr = mul_rd whenever state=PEND, else 0. If mul_rd == 0, wb_mul_we is forced to 0 but PEND still exits on the first free slot.
- stall = id_valid & (any of):
  - state != IDLE & id_mul (single multiply in flight);
  - state != IDLE & mul_rd != 0 & (id_rs == mul_rd | id_rt == mul_rd) (RAW; rt is compared conservatively for all formats);
  - state != IDLE & mul_rd != 0 & id_wr_regfile & id_rd == mul_rd (WAW);
  - state == PEND (drains the pipe so a write slot frees).
- stall=0 when id_valid=0.
- Latency:
  - Fastest writeback is 1 cycle after the mul_done edge.
  - Minimum gap between two multiplies is 2 cycles after mul_done.
- timeout_err clears only on reset.

Decomposition:
- Package mips_ctrl_pkg:
  - state enum {IDLE, BUSY, PEND}, 2 bits;
  - REG_ZERO = 5'd0;
  - opcode/funct constants shared with the decoder (R-type 6'h04, MUL funct 6'h32, LW 6'h05, SW 6'h06).
- Sub-module mul_watchdog: counter with clear/enable/expire.
  - Parameterised by MUL_TIMEOUT; width is clog2(MUL_TIMEOUT).
- Hazard compare and FSM stay in the top module.

Test Plan:
- Reset release, then id_valid=1, id_mul=1, id_rd=8 -> mul_go=1 and id_issue=1 the same cycle; busy=1 next cycle.
- BUSY with mul_rd=8, ID add rs=3 rt=4 rd=9 -> stall=0, id_issue=1; the same with rs=8 -> stall=1 until the PEND write, then issue.
- mul_done pulse with wb_alu_we=1 for 2 cycles -> wb_mul_we=0 for 2 cycles, then wb_mul_we=1, wb_mul_addr=8; stall=1 throughout PEND; IDLE next cycle.
- Second multiply in ID while BUSY -> stall=1, mul_go=0; it issues with mul_go=1 the first IDLE cycle after writeback.
- MUL_TIMEOUT=4, no mul_done -> return to IDLE 4 cycles after mul_go, timeout_err=1 sticky, wb_mul_we never asserted.
- mul_rd=0 multiply -> no hazard stalls in BUSY, wb_mul_we=0 in PEND, state returns to IDLE; rst_n pulled low in BUSY -> all outputs 0 immediately.
